game_tick_sched: RTL and testbench

GAME_TICK_SCHED -- requirements
Module: game_tick_sched

---
 rtl/game_pkg.sv | 31 +++
 rtl/prog_strobe_cnt.sv | 24 ++
 rtl/game_tick_sched.sv | 136 +++++++++++++
 tb/tb_game_tick_sched.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and elaboration-time helpers for the game tick scheduler.
`ifndef BOARD_CLK_MHZ
`define BOARD_CLK_MHZ 100
`endif

package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SERVE  = 2'd1,
    ST_RUN    = 2'd2,
    ST_PAUSED = 2'd3
  } sched_state_t;

  // Clock cycles per ball move at a given level, never below one cycle.
  function automatic int period_f(input int clk_hz, input int base_hz, input int level);
    int div;
    int p;
    div = base_hz * (level + 1);
    if (div < 1) div = 1;
    p = clk_hz / div;
    if (p < 1) p = 1;
    return p;
  endfunction

  // Bit width able to index v values, at least one bit.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/prog_strobe_cnt.sv
// Programmable-period cycle counter with a wrap strobe. The >= compare lets a
// shorter period take effect at once when the count is already past it.
module prog_strobe_cnt #(
  parameter int CW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [CW:0]   period,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          wrap
);

  assign wrap = en && ({1'b0, cnt} >= (period - (CW+1)'(1)));

  // Count while enabled, restart on wrap, clear has priority.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (en)    cnt <= wrap ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/game_tick_sched.sv
// Ball-move tick scheduler: serve delay, level-dependent tick rate, pause,
// and miss/stop handling around one shared strobe counter.
module game_tick_sched
  import game_pkg::*;
#(
  parameter int CLK_HZ         = `BOARD_CLK_MHZ * 1_000_000,
  parameter int BASE_TICK_HZ   = 60,
  parameter int MAX_LEVEL      = 7,
  parameter int HITS_PER_LEVEL = 4,
  parameter int SERVE_TICKS    = 60
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  input  logic                           stop_i,
  input  logic                           pause_i,
  input  logic                           hit_i,
  input  logic                           miss_i,
  output logic                           tick_o,
  output logic                           serve_o,
  output logic [$clog2(MAX_LEVEL+1)-1:0] level_o,
  output sched_state_t                   state_o
);

  localparam int P0 = period_f(CLK_HZ, BASE_TICK_HZ, 0);
  localparam int CW = clog2_min1(P0);
  localparam int LW = $clog2(MAX_LEVEL + 1);
  localparam int HW = clog2_min1(HITS_PER_LEVEL);
  localparam int ST = (SERVE_TICKS < 1) ? 1 : SERVE_TICKS;
  localparam int SW = clog2_min1(ST);

  sched_state_t  state;
  logic [LW-1:0] level;
  logic [HW-1:0] hit_cnt;
  logic [SW-1:0] serve_cnt;
  logic [CW-1:0] cnt;
  logic [CW:0]   period;
  logic          en, clr, wrap;
  logic          is_run, is_serve, is_paused, serve_fire, miss_live;

  // Period per level, constant-folded; no divider survives into hardware.
  logic [CW:0] period_tbl [MAX_LEVEL+1];
  for (genvar g = 0; g <= MAX_LEVEL; g++) begin : g_ptbl
    assign period_tbl[g] = (CW+1)'(period_f(CLK_HZ, BASE_TICK_HZ, g));
  end

  assign is_run     = (state == ST_RUN);
  assign is_serve   = (state == ST_SERVE);
  assign is_paused  = (state == ST_PAUSED);
  assign miss_live  = miss_i && (is_run || is_paused);
  assign serve_fire = is_serve && wrap && (serve_cnt == SW'(ST - 1));

  // Serve always paces at the level-0 rate; run follows the current level.
  assign period = is_run ? period_tbl[level] : period_tbl[0];
  assign en     = is_serve || is_run;
  assign clr    = stop_i || (state == ST_IDLE) || serve_fire || miss_live;

  // Strobes come straight off registered state; stop masks them immediately.
  assign tick_o  = is_run && wrap && !stop_i;
  assign serve_o = serve_fire && !stop_i;
  assign level_o = level;
  assign state_o = state;

  prog_strobe_cnt #(.CW(CW)) u_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .period(period),
    .en    (en),
    .clr   (clr),
    .cnt   (cnt),
    .wrap  (wrap)
  );

  // Game FSM: stop > miss > pause > hit; hits only count while running.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      level     <= '0;
      hit_cnt   <= '0;
      serve_cnt <= '0;
    end else if (stop_i) begin
      state     <= ST_IDLE;
      level     <= '0;
      hit_cnt   <= '0;
      serve_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state     <= ST_SERVE;
            level     <= '0;
            hit_cnt   <= '0;
            serve_cnt <= '0;
          end
        end
        ST_SERVE: begin
          if (serve_fire) begin
            serve_cnt <= '0;
            state     <= ST_RUN;
          end else if (wrap) begin
            serve_cnt <= serve_cnt + SW'(1);
          end
        end
        ST_RUN: begin
          if (miss_i) begin
            state     <= ST_SERVE;
            level     <= '0;
            hit_cnt   <= '0;
            serve_cnt <= '0;
          end else if (pause_i) begin
            state <= ST_PAUSED;
          end else if (hit_i) begin
            if (hit_cnt == HW'(HITS_PER_LEVEL - 1)) begin
              hit_cnt <= '0;
              if (level != LW'(MAX_LEVEL)) level <= level + LW'(1);
            end else begin
              hit_cnt <= hit_cnt + HW'(1);
            end
          end
        end
        ST_PAUSED: begin
          if (miss_i) begin
            state     <= ST_SERVE;
            level     <= '0;
            hit_cnt   <= '0;
            serve_cnt <= '0;
          end else if (pause_i) begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_tick_sched.sv
// Self-checking bench for game_tick_sched: directed timing scenarios plus a
// randomized run against a cycle-level behavioural model of the game rules.
module tb_game_tick_sched;
  import game_pkg::*;

  localparam int CLK_HZ = 1200, BASE_HZ = 100, MAXL = 3, HPL = 2, SERVE_T = 2;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic start_i = 0, stop_i = 0, pause_i = 0, hit_i = 0, miss_i = 0;
  logic tick_o, serve_o;
  logic [1:0] level_o;
  sched_state_t state_o;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  game_tick_sched #(
    .CLK_HZ(CLK_HZ), .BASE_TICK_HZ(BASE_HZ), .MAX_LEVEL(MAXL),
    .HITS_PER_LEVEL(HPL), .SERVE_TICKS(SERVE_T)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
    .pause_i(pause_i), .hit_i(hit_i), .miss_i(miss_i),
    .tick_o(tick_o), .serve_o(serve_o), .level_o(level_o), .state_o(state_o)
  );

  // Behavioural model: state 0..3, running cycles into the current period,
  // level, hits toward next level, completed serve periods.
  int m_state, m_phase, m_level, m_hits, m_serves;
  logic e_tick, e_serve, o_tick, o_serve;
  int e_state, e_level, o_state, o_level;

  function automatic int per(input int l);
    int p;
    p = CLK_HZ / (BASE_HZ * (l + 1));
    return (p < 1) ? 1 : p;
  endfunction

  task automatic m_clear();
    m_phase = 0; m_level = 0; m_hits = 0; m_serves = 0;
  endtask

  task automatic m_update(input logic st, sp, pa, hi, mi);
    logic t;
    if (sp) begin
      m_state = 0; m_clear();
    end else begin
      case (m_state)
        0: if (st) begin m_state = 1; m_clear(); end
        1: begin
          if (m_phase == per(0) - 1) begin
            m_phase = 0;
            m_serves++;
            if (m_serves == SERVE_T) begin m_state = 2; m_serves = 0; end
          end else m_phase++;
        end
        2: begin
          t = (m_phase >= per(m_level) - 1);
          m_phase = t ? 0 : m_phase + 1;
          if (mi) begin m_state = 1; m_clear(); end
          else if (pa) m_state = 3;
          else if (hi) begin
            m_hits++;
            if (m_hits == HPL) begin
              m_hits = 0;
              if (m_level < MAXL) m_level++;
            end
          end
        end
        default: begin
          if (mi) begin m_state = 1; m_clear(); end
          else if (pa) m_state = 2;
        end
      endcase
    end
  endtask

  // One clock cycle: drive at negedge, predict, sample, clock, advance model.
  task automatic step(input logic st, sp, pa, hi, mi);
    @(negedge clk);
    start_i = st; stop_i = sp; pause_i = pa; hit_i = hi; miss_i = mi;
    e_tick  = !sp && m_state == 2 && m_phase >= per(m_level) - 1;
    e_serve = !sp && m_state == 1 && m_phase == per(0) - 1 && m_serves == SERVE_T - 1;
    e_state = m_state; e_level = m_level;
    #2;
    o_tick = tick_o; o_serve = serve_o; o_state = int'(state_o); o_level = int'(level_o);
    @(posedge clk);
    m_update(st, sp, pa, hi, mi);
  endtask

  task automatic start_game();
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 40 && m_state != 2; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (tick_o !== 1'b0 || serve_o !== 1'b0 || state_o !== ST_IDLE || level_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: tick=%b serve=%b state=%0d level=%0d, want 0 0 0 0",
               tick_o, serve_o, state_o, level_o);
    end
    @(negedge clk); rst_i = 1'b0;
    m_state = 0; m_clear();
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
    checks++;
    if (o_state !== 0 || o_tick !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: state=%0d tick=%b, want 0 0", o_state, o_tick);
    end
  endtask

  task automatic test_serve_timing();
    int serve_at, nt;
    int ticks [3];
    step(0, 1, 0, 0, 0);
    serve_at = -1; nt = 0;
    for (int i = 0; i <= 60; i++) begin
      step(i == 0, 0, 0, 0, 0);
      if (o_serve) serve_at = i;
      if (o_tick && nt < 3) begin ticks[nt] = i; nt++; end
      if (o_tick && o_serve) begin
        errors++;
        $display("FAIL strobe_overlap: cycle %0d tick and serve both 1", i);
      end
    end
    checks++;
    if (serve_at != 24) begin
      errors++; $display("FAIL serve_cycle: got %0d, want 24", serve_at);
    end
    checks++;
    if (nt != 3 || ticks[0] != 36 || ticks[1] != 48 || ticks[2] != 60) begin
      errors++;
      $display("FAIL tick_cycles: got n=%0d %0d %0d %0d, want 36 48 60",
               nt, ticks[0], ticks[1], ticks[2]);
    end
    checks++;
    if (o_level != 0) begin
      errors++; $display("FAIL serve_level: got %0d, want 0", o_level);
    end
  endtask

  task automatic test_level_up();
    int prev, nt, bad;
    start_game();
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    prev = -1; nt = 0; bad = 0;
    for (int i = 0; i < 30; i++) begin
      step(0, 0, 0, 0, 0);
      if (o_tick) begin
        if (prev >= 0 && i - prev != 6) bad++;
        prev = i; nt++;
      end
    end
    checks++;
    if (o_level != 1 || nt < 4 || bad != 0) begin
      errors++;
      $display("FAIL level1_spacing: level=%0d ticks=%0d bad_gaps=%0d, want 1 >=4 0", o_level, nt, bad);
    end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0);
    prev = -1; nt = 0; bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0, 0);
      checks++;
      if (o_tick !== e_tick || o_level != e_level) begin
        errors++;
        $display("FAIL level3_model: tick=%b level=%0d, want %b %0d", o_tick, o_level, e_tick, e_level);
      end
      if (o_tick) begin
        if (prev >= 0 && i - prev != 3) bad++;
        prev = i; nt++;
      end
    end
    checks++;
    if (o_level != 3 || nt < 5 || bad != 0) begin
      errors++;
      $display("FAIL level3_spacing: level=%0d ticks=%0d bad_gaps=%0d, want 3 >=5 0", o_level, nt, bad);
    end
  endtask

  task automatic test_stale_cnt();
    int gap;
    start_game();
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    checks++;
    if (o_tick !== 1'b1 || o_level != 1) begin
      errors++;
      $display("FAIL stale_tick: tick=%b level=%0d, want 1 1", o_tick, o_level);
    end
    gap = -1;
    for (int i = 1; i <= 10 && gap < 0; i++) begin
      step(0, 0, 0, 0, 0);
      if (o_tick) gap = i;
    end
    checks++;
    if (gap != 6) begin
      errors++; $display("FAIL stale_gap: got %0d, want 6", gap);
    end
  endtask

  task automatic test_pause();
    int nt, bad_state, first;
    start_game();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    nt = 0; bad_state = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, (i % 3) == 0, 0);
      if (o_tick) nt++;
      if (o_state != 3) bad_state++;
    end
    checks++;
    if (nt != 0 || bad_state != 0 || o_level != 0) begin
      errors++;
      $display("FAIL paused_quiet: ticks=%0d bad_state=%0d level=%0d, want 0 0 0", nt, bad_state, o_level);
    end
    step(0, 0, 1, 0, 0);
    first = -1;
    for (int k = 1; k <= 10 && first < 0; k++) begin
      step(0, 0, 0, 0, 0);
      if (o_tick) first = k;
    end
    checks++;
    if (first != 6) begin
      errors++; $display("FAIL resume_tick: got %0d, want 6", first);
    end
  endtask

  task automatic test_miss_hit();
    int first;
    start_game();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    checks++;
    if (o_level != 2) begin
      errors++; $display("FAIL miss_pre_level: got %0d, want 2", o_level);
    end
    step(0, 0, 0, 1, 1);
    first = -1;
    for (int k = 1; k <= 40 && first < 0; k++) begin
      step(0, 0, 0, 0, 0);
      if (k == 1) begin
        checks++;
        if (o_state != 1 || o_level != 0) begin
          errors++;
          $display("FAIL miss_to_serve: state=%0d level=%0d, want 1 0", o_state, o_level);
        end
      end
      if (o_serve) first = k;
    end
    checks++;
    if (first != 24) begin
      errors++; $display("FAIL miss_serve_delay: got %0d, want 24", first);
    end
  endtask

  task automatic test_reset_mid_run();
    start_game();
    for (int i = 0; i < 20 && m_phase != 11; i++) step(0, 0, 0, 0, 0);
    @(negedge clk);
    start_i = 0; stop_i = 0; pause_i = 0; hit_i = 0; miss_i = 0;
    #1;
    checks++;
    if (tick_o !== 1'b1) begin
      errors++; $display("FAIL pre_reset_tick: got %b, want 1", tick_o);
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if (tick_o !== 1'b0 || serve_o !== 1'b0 || state_o !== ST_IDLE || level_o !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: tick=%b serve=%b state=%0d level=%0d, want 0 0 0 0",
               tick_o, serve_o, state_o, level_o);
    end
    @(posedge clk);
    @(negedge clk); rst_i = 1'b0;
    m_state = 0; m_clear();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    checks++;
    if (o_state != 0) begin
      errors++; $display("FAIL post_reset_idle: state=%0d, want 0", o_state);
    end
  endtask

  task automatic test_stop_serve();
    int ns, bad_state;
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 1; i < 24; i++) step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    checks++;
    if (o_serve !== 1'b0 || o_state != 1) begin
      errors++; $display("FAIL stop_mask_serve: serve=%b state=%0d, want 0 1", o_serve, o_state);
    end
    ns = 0; bad_state = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 0, 0, 0);
      if (o_serve || o_tick) ns++;
      if (o_state != 0) bad_state++;
    end
    checks++;
    if (ns != 0 || bad_state != 0) begin
      errors++; $display("FAIL stop_idle: strobes=%0d bad_state=%0d, want 0 0", ns, bad_state);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 99) < 6, $urandom_range(0, 299) < 2, $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 2);
      checks++;
      if (o_tick !== e_tick) begin
        errors++; $display("FAIL rand_tick @%0d: got %b, want %b", i, o_tick, e_tick);
      end
      checks++;
      if (o_serve !== e_serve) begin
        errors++; $display("FAIL rand_serve @%0d: got %b, want %b", i, o_serve, e_serve);
      end
      checks++;
      if (o_state != e_state || o_level != e_level) begin
        errors++;
        $display("FAIL rand_state @%0d: state=%0d level=%0d, want %0d %0d",
                 i, o_state, o_level, e_state, e_level);
      end
    end
  endtask

  initial begin
    test_reset();
    test_serve_timing();
    test_level_up();
    test_stale_cnt();
    test_pause();
    test_miss_hit();
    test_reset_mid_run();
    test_stop_serve();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
